rgb_fpga_matrix_rx: RTL and testbench

//  Receive side of the HUB75 matrix interface: sinks matrix_* lines as an LED panel would and rebuilds each latched line.

---
 rtl/rgb_fpga_pkg.sv | 23 ++
 rtl/rgb_fpga_sync_edge.sv | 54 +++++
 rtl/rgb_fpga_matrix_rx.sv | 144 ++++++++++++++
 tb/tb_rgb_fpga_matrix_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_fpga_pkg.sv
// rgb_fpga_pkg: shared types and constants for the HUB75 receive path.
// Channel order matches the line_data channel index.
package rgb_fpga_pkg;

  localparam int NUM_CH   = 6;
  localparam int ADDR_W   = 4;
  localparam int DEF_COLS = 32;

  typedef enum logic [2:0] {
    CH_R0,
    CH_G0,
    CH_B0,
    CH_R1,
    CH_G1,
    CH_B1
  } ch_e;

  typedef enum logic {
    WAIT_LAT,
    SHIFT
  } rx_state_e;

endpackage

// File: rtl/rgb_fpga_sync_edge.sv
// rgb_fpga_sync_edge: synchronizer with registered rising-edge pulse.
// Define MATRIX_RX_DEGLITCH_EN to accept only 2-cycle-stable levels.
module rgb_fpga_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sr;
  logic                   s_q;
  logic                   sync;

  assign sync = sr[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      s_q <= 1'b0;
    end else begin
      sr  <= {sr[SYNC_STAGES-2:0], din};
      s_q <= sync;
    end
  end

`ifdef MATRIX_RX_DEGLITCH_EN
  logic filt;
  logic stable;

  assign stable = (sync == s_q);
  assign level  = filt;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b0;
      rise <= 1'b0;
    end else begin
      rise <= stable & sync & ~filt;
      if (stable) filt <= sync;
    end
  end
`else
  assign level = sync;

  always_ff @(posedge clk) begin
    if (rst) rise <= 1'b0;
    else     rise <= sync & ~s_q;
  end
`endif

endmodule

// File: rtl/rgb_fpga_matrix_rx.sv
// rgb_fpga_matrix_rx: HUB75 receiver rebuilding each latched line.
// Define MATRIX_RX_DEGLITCH_EN to reject 1-cycle clk/lat pulses.
module rgb_fpga_matrix_rx
  import rgb_fpga_pkg::*;
#(
  parameter int COLS        = DEF_COLS,
  parameter int SYNC_STAGES = 2,
  parameter int ONTIME_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        matrix_r0,
  input  logic                        matrix_g0,
  input  logic                        matrix_b0,
  input  logic                        matrix_r1,
  input  logic                        matrix_g1,
  input  logic                        matrix_b1,
  input  logic                        matrix_clk,
  input  logic                        matrix_lat,
  input  logic                        matrix_oe,
  input  logic [ADDR_W-1:0]           matrix_addr,
  output logic                        line_valid,
  output logic [NUM_CH-1:0][COLS-1:0] line_data,
  output logic [ADDR_W-1:0]           line_addr,
  output logic                        line_len_err,
  output logic [ONTIME_W-1:0]         on_time
);

  localparam int PW = NUM_CH + 1 + ADDR_W;
  localparam int CW = $clog2(COLS + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(COLS);
  localparam logic [CW-1:0] CNT_SAT  = CW'(COLS + 1);

  logic [SYNC_STAGES-1:0][PW-1:0] p_sr;
  logic [PW-1:0]                  p_a;
  logic [NUM_CH-1:0]              d_a;
  logic                           oe_a;
  logic [ADDR_W-1:0]              addr_a;
  logic                           clk_rise, lat_rise;
  logic                           clk_lvl, lat_lvl;
  logic                           unused_lvl;
  rx_state_e                      state_q, state_d;
  logic [NUM_CH-1:0][COLS-1:0]    shreg, shreg_nx;
  logic [CW-1:0]                  col_cnt, col_nx;
  logic [ONTIME_W-1:0]            ont_cnt;
  logic                           in_shift;

  rgb_fpga_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_se (
    .clk   (clk),
    .rst   (rst),
    .din   (matrix_clk),
    .level (clk_lvl),
    .rise  (clk_rise)
  );

  rgb_fpga_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lat_se (
    .clk   (clk),
    .rst   (rst),
    .din   (matrix_lat),
    .level (lat_lvl),
    .rise  (lat_rise)
  );

  assign unused_lvl = clk_lvl ^ lat_lvl;

  // Extra stage keeps data/oe/addr aligned with the registered edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_sr <= '0;
      p_a  <= '0;
    end else begin
      p_sr <= {p_sr[SYNC_STAGES-2:0],
               {matrix_addr, matrix_oe,
                matrix_b1, matrix_g1, matrix_r1,
                matrix_b0, matrix_g0, matrix_r0}};
      p_a  <= p_sr[SYNC_STAGES-1];
    end
  end

  assign d_a    = p_a[NUM_CH-1:0];
  assign oe_a   = p_a[NUM_CH];
  assign addr_a = p_a[PW-1 -: ADDR_W];

  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_LAT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LAT: if (enable && lat_rise) state_d = SHIFT;
      SHIFT:    if (!enable) state_d = WAIT_LAT;
      default:  state_d = WAIT_LAT;
    endcase
  end

  assign in_shift = (state_q == SHIFT) && enable;

  // Shift precedes latch so a same-cycle clk edge lands in the line.
  always_comb begin
    shreg_nx = shreg;
    col_nx   = col_cnt;
    if (in_shift && clk_rise) begin
      for (int ch = 0; ch < NUM_CH; ch++)
        shreg_nx[ch] = {shreg[ch][COLS-2:0], d_a[ch]};
      if (col_cnt != CNT_SAT) col_nx = col_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg        <= '0;
      col_cnt      <= '0;
      ont_cnt      <= '0;
      line_valid   <= 1'b0;
      line_data    <= '0;
      line_addr    <= '0;
      line_len_err <= 1'b0;
      on_time      <= '0;
    end else begin
      line_valid <= 1'b0;
      if (!in_shift) begin
        col_cnt <= '0;
        ont_cnt <= '0;
      end else begin
        shreg   <= shreg_nx;
        col_cnt <= col_nx;
        if (!oe_a && ont_cnt != '1) ont_cnt <= ont_cnt + ONTIME_W'(1);
        if (lat_rise) begin
          line_data    <= shreg_nx;
          line_addr    <= addr_a;
          line_len_err <= (col_nx != CNT_FULL);
          on_time      <= ont_cnt;
          col_cnt      <= '0;
          ont_cnt      <= '0;
          line_valid   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_fpga_matrix_rx.sv
// tb_rgb_fpga_matrix_rx: directed bench for the HUB75 line receiver.
// Honors MATRIX_RX_DEGLITCH_EN for latency and glitch steps.
module tb_rgb_fpga_matrix_rx;
  import rgb_fpga_pkg::*;

`ifdef MATRIX_RX_DEGLITCH_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic matrix_r0 = 0, matrix_g0 = 0, matrix_b0 = 0;
  logic matrix_r1 = 0, matrix_g1 = 0, matrix_b1 = 0;
  logic matrix_clk = 0, matrix_lat = 0, matrix_oe = 1;
  logic [ADDR_W-1:0] matrix_addr = '0;
  logic line_valid;
  logic [NUM_CH-1:0][31:0] line_data;
  logic [ADDR_W-1:0] line_addr;
  logic line_len_err;
  logic [15:0] on_time;

  int checks = 0;
  int failures = 0;
  int vcnt = 0;

  rgb_fpga_matrix_rx dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .matrix_r0    (matrix_r0),
    .matrix_g0    (matrix_g0),
    .matrix_b0    (matrix_b0),
    .matrix_r1    (matrix_r1),
    .matrix_g1    (matrix_g1),
    .matrix_b1    (matrix_b1),
    .matrix_clk   (matrix_clk),
    .matrix_lat   (matrix_lat),
    .matrix_oe    (matrix_oe),
    .matrix_addr  (matrix_addr),
    .line_valid   (line_valid),
    .line_data    (line_data),
    .line_addr    (line_addr),
    .line_len_err (line_len_err),
    .on_time      (on_time)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && line_valid) vcnt++;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic r0v, input logic g0v,
                          input logic b1v);
    matrix_r0 = r0v;
    matrix_g0 = g0v;
    matrix_b1 = b1v;
    tick(2);
    matrix_clk = 1'b1;
    tick(2);
    matrix_clk = 1'b0;
  endtask

  task automatic send_line(input logic [63:0] r0w,
                           input logic [63:0] g0w,
                           input logic [63:0] b1w,
                           input int n);
    for (int i = n - 1; i >= 0; i--)
      send_bit(r0w[i], g0w[i], b1w[i]);
    matrix_r0 = 1'b0;
    matrix_g0 = 1'b0;
    matrix_b1 = 1'b0;
  endtask

  task automatic pulse_lat();
    tick(2);
    matrix_lat = 1'b1;
    tick(3);
    matrix_lat = 1'b0;
    tick(8);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_valid", 64'(line_valid), 64'd0);
    check("rst_data", 64'(line_data), 64'd0);
    check("rst_addr", 64'(line_addr), 64'd0);
    check("rst_lenerr", 64'(line_len_err), 64'd0);
    check("rst_ontime", 64'(on_time), 64'd0);

    enable = 1'b1;
    tick(2);
    pulse_lat();
    check("prime_novalid", 64'(vcnt), 64'd0);

    matrix_addr = 4'd5;
    send_line(64'h8000_0006, 64'h0000_0003, 64'hA5A5_0F0F, 32);
    tick(2);
    matrix_lat = 1'b1;
    @(posedge clk);
    repeat (LAT - 1) @(posedge clk);
    #1 check("lat_early", 64'(line_valid), 64'd0);
    @(posedge clk);
    #1 check("lat_exact", 64'(line_valid), 64'd1);
    @(posedge clk);
    #1 check("lat_strobe", 64'(line_valid), 64'd0);
    @(negedge clk);
    matrix_lat = 1'b0;
    tick(8);
    check("t1_vcnt", 64'(vcnt), 64'd1);
    check("t1_r0", 64'(line_data[int'(CH_R0)]), 64'h8000_0006);
    check("t1_g0", 64'(line_data[int'(CH_G0)]), 64'h0000_0003);
    check("t1_b1", 64'(line_data[int'(CH_B1)]), 64'hA5A5_0F0F);
    check("t1_r1", 64'(line_data[int'(CH_R1)]), 64'h0);
    check("t1_addr", 64'(line_addr), 64'd5);
    check("t1_lenerr", 64'(line_len_err), 64'd0);

    send_line(64'h7FFF_FFFF, 64'h0, 64'h0, 31);
    pulse_lat();
    check("t2_short_vcnt", 64'(vcnt), 64'd2);
    check("t2_short_err", 64'(line_len_err), 64'd1);
    send_line(64'h1_8000_0001, 64'h0, 64'h0, 33);
    pulse_lat();
    check("t2_long_vcnt", 64'(vcnt), 64'd3);
    check("t2_long_err", 64'(line_len_err), 64'd1);
    check("t2_long_r0", 64'(line_data[int'(CH_R0)]), 64'h8000_0001);

    matrix_oe = 1'b0;
    tick(100);
    matrix_oe = 1'b1;
    tick(4);
    pulse_lat();
    check("t3_on100", 64'(on_time), 64'd100);
    matrix_oe = 1'b0;
    tick(70000);
    matrix_oe = 1'b1;
    tick(4);
    pulse_lat();
    check("t3_sat", 64'(on_time), 64'd65535);
    check("t3_vcnt", 64'(vcnt), 64'd5);

    send_line(64'hFFFF, 64'h0, 64'h0, 16);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    check("t4_rst_r0", 64'(line_data[int'(CH_R0)]), 64'h0);
    check("t4_rst_ont", 64'(on_time), 64'd0);
    send_line(64'hFFFF_FFFF, 64'h0, 64'h0, 32);
    pulse_lat();
    check("t4_novalid", 64'(vcnt), 64'd5);
    send_line(64'h1234_5678, 64'h0, 64'h0, 32);
    pulse_lat();
    check("t4_vcnt", 64'(vcnt), 64'd6);
    check("t4_lenerr", 64'(line_len_err), 64'd0);
    check("t4_r0", 64'(line_data[int'(CH_R0)]), 64'h1234_5678);

    send_line(64'h0, 64'h0, 64'h0, 31);
    matrix_r0 = 1'b1;
    tick(2);
    matrix_clk = 1'b1;
    matrix_lat = 1'b1;
    tick(3);
    matrix_clk = 1'b0;
    matrix_lat = 1'b0;
    matrix_r0 = 1'b0;
    tick(8);
    check("t5_vcnt", 64'(vcnt), 64'd7);
    check("t5_lenerr", 64'(line_len_err), 64'd0);
    check("t5_r0", 64'(line_data[int'(CH_R0)]), 64'h0000_0001);

    enable = 1'b0;
    matrix_addr = 4'd9;
    send_line(64'hFFFF_FFFF, 64'h0, 64'h0, 32);
    pulse_lat();
    check("t6_novalid", 64'(vcnt), 64'd7);
    check("t6_hold_r0", 64'(line_data[int'(CH_R0)]), 64'h0000_0001);
    check("t6_hold_addr", 64'(line_addr), 64'd5);
    check("t6_hold_err", 64'(line_len_err), 64'd0);
    enable = 1'b1;
    tick(2);
    pulse_lat();
    check("t6_prime", 64'(vcnt), 64'd7);
    send_line(64'hFFFF, 64'h0, 64'h0, 16);
`ifdef MATRIX_RX_DEGLITCH_EN
    tick(2);
    matrix_clk = 1'b1;
    tick(1);
    matrix_clk = 1'b0;
    tick(2);
`endif
    send_line(64'h0, 64'h0, 64'h0, 16);
    pulse_lat();
    check("t6_vcnt", 64'(vcnt), 64'd8);
    check("t6_lenerr", 64'(line_len_err), 64'd0);
    check("t6_r0", 64'(line_data[int'(CH_R0)]), 64'hFFFF_0000);
    check("t6_addr", 64'(line_addr), 64'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
